// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Multiplication uses radix-2 shift-add and division uses the restoring algorithm.
// Both run on operand magnitudes, and the sign correction happens on the way out.
// The latency is fixed: one PREP cycle, XLEN CALC cycles, then one FIN cycle.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [4:0]      rd_sel_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] rd,
  output logic [4:0]      rd_sel,
  output logic            we
);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_CALC, S_FIN} state_t;

  localparam logic [5:0] CNT_INIT = 6'(XLEN);

  state_t                state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [XLEN-1:0]       a_q, a_d;
  logic [XLEN-1:0]       b_q, b_d;
  logic [4:0]            sel_q, sel_d;
  logic [2*XLEN-1:0]     acc_q, acc_d;
  logic [XLEN-1:0]       mag_q, mag_d;
  logic [5:0]            cnt_q, cnt_d;
  logic                  neg_q, neg_d;
  logic                  dz_q, dz_d;
  logic                  ov_q, ov_d;
  logic [XLEN-1:0]       rd_q, rd_d;
  logic [4:0]            rdsel_q, rdsel_d;

  logic                  is_mul;
  logic                  a_signed, b_signed;
  logic                  sa, sb;
  logic [XLEN-1:0]       ma, mb;
  logic [XLEN:0]         upper, r_sh, diff;
  logic [2*XLEN-1:0]     prod_s;
  logic [XLEN-1:0]       q_s, r_s;
  logic [XLEN-1:0]       res;

  // Conditional two's-complement negation (single width).
  function automatic logic [XLEN-1:0] cond_neg(input logic n, input logic [XLEN-1:0] v);
    return n ? (~v + 1'b1) : v;
  endfunction

  // Conditional two's-complement negation of a full-width product.
  function automatic logic [2*XLEN-1:0] cond_neg2(input logic n, input logic [2*XLEN-1:0] v);
    return n ? (~v + 1'b1) : v;
  endfunction

  // Operand signedness and magnitudes of the captured operation.
  // MUL takes the unsigned path because only its low half is kept.
  assign is_mul   = ~op_q[2];
  assign a_signed = op_q[2] ? ~op_q[0] : (op_q[1:0] == 2'b01 || op_q[1:0] == 2'b10);
  assign b_signed = op_q[2] ? ~op_q[0] : (op_q[1:0] == 2'b01);
  assign sa       = a_signed & a_q[XLEN-1];
  assign sb       = b_signed & b_q[XLEN-1];
  assign ma       = cond_neg(sa, a_q);
  assign mb       = cond_neg(sb, b_q);

  // One iteration step. The multiply adds into the upper half and then shifts right.
  // The divide shifts the next dividend bit into the remainder and then trial-subtracts.
  assign upper = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_q} : '0);
  assign r_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign diff  = r_sh - {1'b0, mag_q};

  // Sign-corrected result selection, with the divide special cases overriding it.
  always_comb begin
    prod_s = cond_neg2(neg_q, acc_q);
    q_s    = cond_neg(neg_q, acc_q[XLEN-1:0]);
    r_s    = cond_neg(neg_q, acc_q[2*XLEN-1:XLEN]);
    res    = '0;
    if (is_mul) begin
      res = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end else if (dz_q) begin
      res = op_q[1] ? a_q : '1;
    end else if (ov_q) begin
      res = op_q[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end else begin
      res = op_q[1] ? r_s : q_s;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and control outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_PREP;
      S_PREP: begin
        busy    = 1'b1;
        state_d = S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (cnt_q == 6'd1) state_d = S_FIN;
      end
      S_FIN: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rd     = done ? res : rd_q;
  assign rd_sel = done ? sel_q : rdsel_q;
  assign we     = done && (rd_sel != 5'd0);

  // Datapath next-state: capture, prepare, iterate, publish.
  always_comb begin
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    acc_d   = acc_q;
    mag_d   = mag_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    rd_d    = rd_q;
    rdsel_d = rdsel_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = funct3;
          a_d   = rs1;
          b_d   = rs2;
          sel_d = rd_sel_in;
        end
      end
      S_PREP: begin
        cnt_d = CNT_INIT;
        if (is_mul) begin
          mag_d = ma;
          acc_d = {{XLEN{1'b0}}, mb};
          neg_d = sa ^ sb;
          dz_d  = 1'b0;
          ov_d  = 1'b0;
        end else begin
          mag_d = mb;
          acc_d = {{XLEN{1'b0}}, ma};
          neg_d = op_q[1] ? sa : (sa ^ sb);
          dz_d  = (b_q == '0);
          ov_d  = ~op_q[0] && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
        end
      end
      S_CALC: begin
        cnt_d = cnt_q - 6'd1;
        if (is_mul) begin
          acc_d = {upper, acc_q[XLEN-1:1]};
        end else if (!diff[XLEN]) begin
          acc_d = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
          acc_d = {r_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end
      end
      S_FIN: begin
        rd_d    = res;
        rdsel_d = sel_q;
      end
      default: ;
    endcase
  end

  // Datapath registers; everything clears on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      acc_q   <= '0;
      mag_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
      rd_q    <= '0;
      rdsel_q <= '0;
    end else begin
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      acc_q   <= acc_d;
      mag_q   <= mag_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
      rd_q    <= rd_d;
      rdsel_q <= rdsel_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: table of operations plus multi-cycle corner sequences.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [4:0]  rd_sel_in;
  logic        busy;
  logic        done;
  logic [31:0] rd;
  logic [4:0]  rd_sel;
  logic        we;

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .rd_sel_in(rd_sel_in),
    .busy(busy), .done(done), .rd(rd), .rd_sel(rd_sel), .we(we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  s;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present an operation during one cycle; returns in the following cycle (N+1).
  task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] s);
    @(negedge clk);
    funct3 = f; rs1 = a; rs2 = b; rd_sel_in = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done; lat is the cycle offset from the start cycle, -1 on timeout.
  task automatic wait_done(input int from, output int lat);
    lat = from;
    while (done !== 1'b1 && lat < 80) begin
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) lat = -1;
  endtask

  initial begin
    int lat;
    int nd;
    rst = 1'b1; start = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0; rd_sel_in = '0;

    vt[0]  = '{3'b000, 32'd7,         32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB};
    vt[1]  = '{3'b001, 32'h80000000,  32'h80000000, 5'd6,  32'h40000000};
    vt[2]  = '{3'b011, 32'h80000000,  32'h80000000, 5'd7,  32'h40000000};
    vt[3]  = '{3'b010, 32'hFFFFFFFF,  32'd2,        5'd8,  32'hFFFFFFFF};
    vt[4]  = '{3'b100, 32'd5,         32'd0,        5'd9,  32'hFFFFFFFF};
    vt[5]  = '{3'b111, 32'd5,         32'd0,        5'd10, 32'd5};
    vt[6]  = '{3'b100, 32'h80000000,  32'hFFFFFFFF, 5'd11, 32'h80000000};
    vt[7]  = '{3'b110, 32'h80000000,  32'hFFFFFFFF, 5'd12, 32'd0};
    vt[8]  = '{3'b100, 32'hFFFFFFF9,  32'd2,        5'd13, 32'hFFFFFFFD};
    vt[9]  = '{3'b110, 32'hFFFFFFF9,  32'd2,        5'd14, 32'hFFFFFFFF};
    vt[10] = '{3'b101, 32'hFFFFFFFF,  32'd2,        5'd15, 32'h7FFFFFFF};
    vt[11] = '{3'b001, 32'hFFFFFFFF,  32'hFFFFFFFF, 5'd16, 32'd0};
    vt[12] = '{3'b011, 32'hFFFFFFFF,  32'hFFFFFFFF, 5'd17, 32'hFFFFFFFE};
    vt[13] = '{3'b000, 32'h12345678,  32'h10,       5'd18, 32'h23456780};
    vt[14] = '{3'b111, 32'd100,       32'd7,        5'd19, 32'd2};
    vt[15] = '{3'b100, 32'd7,         32'hFFFFFFFE, 5'd20, 32'hFFFFFFFD};
    vt[16] = '{3'b110, 32'd7,         32'hFFFFFFFE, 5'd21, 32'd1};
    vt[17] = '{3'b110, 32'hFFFFFFFD,  32'd0,        5'd31, 32'hFFFFFFFD};

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_done",   {31'd0, done}, 32'd0);
    chk("rst_we",     {31'd0, we},   32'd0);
    chk("rst_rd",     rd,            32'd0);
    chk("rst_rd_sel", {27'd0, rd_sel}, 32'd0);

    // Table-driven operations
    for (int i = 0; i < 18; i++) begin
      launch(vt[i].f, vt[i].a, vt[i].b, vt[i].s);
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
      wait_done(1, lat);
      chk($sformatf("v%0d_lat", i),    32'(lat), 32'd34);
      chk($sformatf("v%0d_rd", i),     rd, vt[i].exp);
      chk($sformatf("v%0d_rd_sel", i), {27'd0, rd_sel}, {27'd0, vt[i].s});
      chk($sformatf("v%0d_we", i),     {31'd0, we}, {31'd0, (vt[i].s != 5'd0)});
    end

    // rd/rd_sel hold after done
    @(negedge clk);
    chk("hold_done", {31'd0, done}, 32'd0);
    chk("hold_rd",   rd, 32'hFFFFFFFD);
    chk("hold_sel",  {27'd0, rd_sel}, 32'd31);

    // rd_sel_in=0, operands changed while busy, second start at N+5 ignored
    launch(3'b000, 32'd3, 32'd4, 5'd0);
    @(negedge clk);
    rs1 = 32'hDEADBEEF; rs2 = 32'h55555555; rd_sel_in = 5'd3;
    repeat (3) @(negedge clk);
    funct3 = 3'b100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(6, lat);
    chk("z_lat",    32'(lat), 32'd34);
    chk("z_rd",     rd, 32'd12);
    chk("z_we",     {31'd0, we}, 32'd0);
    chk("z_rd_sel", {27'd0, rd_sel}, 32'd0);
    nd = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    chk("z_extra_done", 32'(nd), 32'd0);

    // start held through FIN: ignored in FIN, accepted the following cycle
    launch(3'b000, 32'd6, 32'd7, 5'd2);
    wait_done(1, lat);
    chk("f_lat1", 32'(lat), 32'd34);
    chk("f_rd1",  rd, 32'd42);
    funct3 = 3'b101; rs1 = 32'd100; rs2 = 32'd9; rd_sel_in = 5'd4; start = 1'b1;
    @(negedge clk);
    chk("f_idle_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    wait_done(1, lat);
    chk("f_lat2",    32'(lat), 32'd34);
    chk("f_rd2",     rd, 32'd11);
    chk("f_rd_sel2", {27'd0, rd_sel}, 32'd4);

    // Reset mid-CALC
    launch(3'b011, 32'hFFFFFFFF, 32'd3, 5'd7);
    for (int i = 2; i <= 10; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("r_busy",   {31'd0, busy}, 32'd0);
    chk("r_done",   {31'd0, done}, 32'd0);
    chk("r_we",     {31'd0, we},   32'd0);
    chk("r_rd",     rd, 32'd0);
    chk("r_rd_sel", {27'd0, rd_sel}, 32'd0);
    nd = 0;
    for (int i = 12; i <= 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 || we === 1'b1) nd++;
    end
    chk("r_no_done", 32'(nd), 32'd0);
    launch(3'b101, 32'hFFFFFFFF, 32'd2, 5'd9);
    wait_done(1, lat);
    chk("r_lat",  32'(lat), 32'd34);
    chk("r_rd2",  rd, 32'h7FFFFFFF);
    chk("r_we2",  {31'd0, we}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
